// File: rtl/img_ram_stream_ctrl_pkg.sv
// Shared constants and types for the image-RAM pixel streamer.
package img_pkg;

  localparam int IMG_ADDR_W = 12;
  localparam int IMG_DATA_W = 8;
  localparam int IMG_DIM_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One stream beat: pixel plus its frame/line markers.
  typedef struct packed {
    logic                  eof;
    logic                  eol;
    logic                  sof;
    logic [IMG_DATA_W-1:0] data;
  } pix_beat_t;

  localparam int IMG_BEAT_W = $bits(pix_beat_t);

endpackage

// File: rtl/img_ram_stream_ctrl_if.sv
// RAM read port plus pixel stream, bundled for the streamer.
interface img_ram_stream_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  // streamer side
  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  // RAM + downstream side
  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/img_ram_stream_ctrl_skid.sv
// 2-entry first-word-fall-through FIFO of pixel beats. When empty, an
// incoming beat is visible on dout in the same cycle it is pushed, which
// hides the RAM latency; if it is not popped it is stored and held.
module pix_skid_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         wr, rd;

  assign valid = (cnt != 2'd0) || push;
  assign dout  = (cnt != 2'd0) ? mem[rd_ptr] : din;
  // a beat bypassed and consumed in the same cycle never lands in storage
  assign wr    = push && !(pop && (cnt == 2'd0));
  assign rd    = pop && (cnt != 2'd0);

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr} - {1'b0, rd};
    end
  end
endmodule

// File: rtl/img_ram_stream_ctrl.sv
// Raster-order image RAM reader producing a valid/ready pixel stream with
// sof/eol/eof markers. Reads are credit-limited so that reads in flight
// plus buffered beats never exceed the 2-entry skid FIFO.
module img_ram_stream_ctrl
  import img_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = IMG_DATA_W,
  parameter int DIM_W  = IMG_DIM_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [DIM_W-1:0]     img_w,
  input  logic [DIM_W-1:0]     img_h,
  output logic                 busy,
  output logic                 done,
  img_ram_stream_ctrl_if.master bus
);
  localparam int BEAT_W = DATA_W + 3;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DIM_W-1:0]  w_q, h_q, x_q, y_q;
  logic              rd_vld;      // a read issued last cycle returns now
  logic [2:0]        tag_q;       // {eof,eol,sof} of the returning read
  logic              rd_en;
  logic              t_sof, t_eol, t_eof;
  logic [1:0]        fifo_cnt;
  logic              head_vld, pop;
  logic [BEAT_W-1:0] push_beat, head_beat;

  // markers of the pixel being requested this cycle
  assign t_sof = (x_q == '0) && (y_q == '0);
  assign t_eol = (x_q == w_q - DIM_W'(1));
  assign t_eof = t_eol && (y_q == h_q - DIM_W'(1));

  // credit: outstanding read + stored beats must leave room for one more
  assign rd_en = (state == S_RUN) && (({1'b0, rd_vld} + fifo_cnt) < 2'd2);

  // control FSM, frame capture and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      addr_q <= '0;
      w_q    <= '0;
      h_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            w_q    <= img_w;
            h_q    <= img_h;
            x_q    <= '0;
            y_q    <= '0;
            busy   <= 1'b1;
            if ((img_w == '0) || (img_h == '0)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (rd_en) begin
            // raster order is contiguous, so the running offset is +1
            addr_q <= addr_q + ADDR_W'(1);
            if (t_eol) begin
              x_q <= '0;
              y_q <= y_q + DIM_W'(1);
            end else begin
              x_q <= x_q + DIM_W'(1);
            end
            if (t_eof) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && head_beat[BEAT_W-1]) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // pipe the issue-time markers alongside the RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      tag_q  <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) tag_q <= {t_eof, t_eol, t_sof};
    end
  end

  assign push_beat = {tag_q, bus.mem_rd_data};
  assign pop       = head_vld && bus.pix_ready;

  pix_skid_fifo #(.W(BEAT_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_vld),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head_beat),
    .valid (head_vld),
    .cnt   (fifo_cnt)
  );

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? addr_q : '0;
  assign bus.pix_valid = head_vld;
  assign {bus.pix_eof, bus.pix_eol, bus.pix_sof, bus.pix_data} =
    head_vld ? head_beat : '0;

endmodule

// File: tb/tb_img_ram_stream_ctrl.sv
// Bench for img_ram_stream_ctrl: table of frames, hand sequences for
// restart-while-busy and mid-frame reset, then random frames, all checked
// against a raster model of the expected pixel stream.
module tb_img_ram_stream_ctrl;
  import img_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [7:0]  img_w = '0, img_h = '0;
  logic        busy, done;

  img_ram_stream_ctrl_if bus ();

  img_ram_stream_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .img_w     (img_w),
    .img_h     (img_h),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM model, 1 cycle latency
  logic [7:0] ram [4096];
  logic [7:0] ram_q = '0;
  always @(posedge clk) if (bus.mem_rd_en) ram_q <= ram[bus.mem_addr];
  assign bus.mem_rd_data = ram_q;

  typedef struct {
    int base;
    int w;
    int h;
    int rdy;
    int npix;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0, rdy_pct = 100;
  int issued, accepted, done_cnt, first_vld_cyc, last_hs_cyc, done_cyc, start_cyc;
  pix_beat_t got[$];
  int        rd_addrs[$];
  bit        prev_stall = 1'b0;
  pix_beat_t prev_beat;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: drives pix_ready and records every read and handshake
  always @(negedge clk) begin : mon
    pix_beat_t cur;
    if (!rst_n) begin
      bus.pix_ready = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      cyc++;
      bus.pix_ready = ($urandom_range(99) < rdy_pct);
      cur = {bus.pix_eof, bus.pix_eol, bus.pix_sof, bus.pix_data};
      if (start && !busy) start_cyc = cyc;
      if (bus.mem_rd_en) begin
        // issued but not yet handed downstream must be below 2
        chk("credit", int'((issued - accepted) < 2), 1);
        rd_addrs.push_back(int'(bus.mem_addr));
        issued++;
      end
      if (prev_stall) begin
        chk("hold_valid", int'(bus.pix_valid), 1);
        chk("hold_beat", int'(cur), int'(prev_beat));
      end
      if (bus.pix_valid) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bus.pix_ready) begin
          got.push_back(cur);
          accepted++;
          last_hs_cyc = cyc;
        end
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_beat  = cur;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  task automatic clear_mon();
    got.delete();
    rd_addrs.delete();
    issued = 0; accepted = 0; done_cnt = 0;
    first_vld_cyc = -1; last_hs_cyc = -1; done_cyc = -1; start_cyc = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(bus.mem_rd_en), 0);
    chk({tag, "_addr"},  int'(bus.mem_addr), 0);
    chk({tag, "_valid"}, int'(bus.pix_valid), 0);
    chk({tag, "_data"},  int'(bus.pix_data), 0);
    chk({tag, "_tags"},  int'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
  endtask

  // start a frame; optionally pulse a conflicting start while busy
  task automatic run_frame(input int base, input int w, input int h,
                           input int rdy, input int restart_at);
    int budget;
    int n;
    budget = 100 + 20 * w * h;
    clear_mon();
    rdy_pct = rdy;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'(base); img_w = 8'(w); img_h = 8'(h);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (restart_at > 0 && n == restart_at) begin
        start = 1'b1; base_addr = 12'h300; img_w = 8'd2; img_h = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("done_in_budget", int'(done_cnt != 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // raster model: expected beats and addresses straight from the frame rules
  task automatic check_frame(input int base, input int w, input int h,
                             input int rdy, input int npix);
    int n;
    pix_beat_t e;
    n = 0;
    chk("npix", got.size(), npix);
    chk("nreads", rd_addrs.size(), npix);
    chk("done_cnt", done_cnt, 1);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int a;
        a      = (base + y * w + x) % 4096;
        e.sof  = (x == 0 && y == 0);
        e.eol  = (x == w - 1);
        e.eof  = (x == w - 1 && y == h - 1);
        e.data = ram[a];
        if (n < got.size())      chk("pixel", int'(got[n]), int'(e));
        if (n < rd_addrs.size()) chk("rd_addr", rd_addrs[n], a);
        n++;
      end
    end
    if (npix == 0) begin
      chk("zero_done_lat", done_cyc - start_cyc, 1);
      chk("zero_no_valid", first_vld_cyc, -1);
    end else if (rdy == 100) begin
      chk("first_lat", first_vld_cyc - start_cyc, 2);
      chk("stream_len", last_hs_cyc - first_vld_cyc, npix - 1);
      chk("done_lat", done_cyc - last_hs_cyc, 1);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[8];
    int   n;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);

    vecs[0] = '{'h010, 4, 3, 100, 12};
    vecs[1] = '{'h010, 4, 3,  50, 12};
    vecs[2] = '{'h020, 0, 3, 100,  0};
    vecs[3] = '{'h020, 4, 0, 100,  0};
    vecs[4] = '{'hFFE, 3, 1, 100,  3};
    vecs[5] = '{'h005, 1, 4, 100,  4};
    vecs[6] = '{'h100, 1, 1, 100,  1};
    vecs[7] = '{'h040, 5, 2,  30, 10};

    // reset state
    #1 rst_n = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].base, vecs[i].w, vecs[i].h, vecs[i].rdy, 0);
      check_frame(vecs[i].base, vecs[i].w, vecs[i].h, vecs[i].rdy, vecs[i].npix);
    end

    // start while busy is ignored: original 4x3 frame, one done
    run_frame('h010, 4, 3, 100, 3);
    check_frame('h010, 4, 3, 100, 12);
    chk("idle_after_restart", int'(busy), 0);

    // reset mid-frame, then replay from sof
    clear_mon();
    rdy_pct = 100;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h010; img_w = 8'd4; img_h = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (accepted < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("mid_reached", int'(accepted >= 5), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame('h010, 4, 3, 100, 0);
    check_frame('h010, 4, 3, 100, 12);

    // random content, geometry and backpressure
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      int b, w, h, r;
      b = int'($urandom_range(4095));
      w = int'($urandom_range(6));
      h = int'($urandom_range(4));
      r = int'($urandom_range(100, 20));
      run_frame(b, w, h, r, 0);
      check_frame(b, w, h, r, w * h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
